aes_stream_adapter: RTL
=======================

# aes_stream_adapter

Parametrised stream adapter around the AES decrypt core. It gathers IN_W-bit ciphertext words into 128-bit blocks and presents each block to the core with a valid/ready handshake. It captures each 128-bit plaintext result and serialises it as OUT_W-bit beats with valid/ready/last. Both sides support full backpressure, flush, and zero-bubble block hand-off.

## Interface
- IN_W, 8, input word width; one of 8/16/32/64/128; NI = 128/IN_W words per block.
- OUT_W, 64, output beat width; one of 8/16/32/64/128; NO = 128/OUT_W beats per block.
- CNT_W, 16, width of the block counters.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard the partially gathered input block.
- s_data  in  IN_W  ciphertext word; first word of a block is the most significant.
- s_vld  in  1  s_data valid.
- s_rdy  out  1  adapter accepts s_data this cycle.
- core_ct  out  128  assembled ciphertext block to the core.
- core_ct_vld  out  1  core_ct valid; held until accepted.
- core_ct_rdy  in  1  core accepts core_ct.
- core_pt  in  128  plaintext result from the core.
- core_pt_vld  in  1  core_pt valid; core holds it until accepted.
- core_pt_rdy  out  1  adapter accepts core_pt.
- m_data  out  OUT_W  plaintext beat; first beat is core_pt[127 -: OUT_W].
- m_vld  out  1  m_data valid.
- m_rdy  in  1  downstream accepts beat.
- m_last  out  1  final beat of a block.
- blk_in_cnt  out  CNT_W  blocks handed to the core (wrapping).
- blk_out_cnt  out  CNT_W  blocks fully emitted on m_* (wrapping).

## Operation
- **Input gather**
  - A word index runs 0..NI-1, with width max(1, clog2(NI)).
  - Each accepted word (s_vld & s_rdy) shifts the gather register left by IN_W and inserts s_data at the LSBs.
  - On acceptance of word NI-1, core_ct_vld sets, the index resets to 0, and the register is frozen as core_ct.
- **s_rdy** = !rst & !flush & (!core_ct_vld | core_ct_rdy).
  - While the block is handed off (core_ct_vld & core_ct_rdy), the first word of the next block may be accepted in the same cycle. The new word shifts into a cleared register.
  - core_ct_rdy → s_rdy is combinational by design.
- **core_ct_vld** clears on handshake unless that same cycle also completes a new block. This is only possible when NI=1, in which case it stays set with the new data.
- **blk_in_cnt** increments on each core_ct handshake.
- **Flush**
  - Clears the word index and gather register when core_ct_vld=0.
  - A block already presented (core_ct_vld=1) is not affected.
  - Flush has priority over s_vld in the same cycle: the word is dropped because s_rdy=0.
  - Flush never affects the output side.
- **Output FSM**
  - IDLE: m_vld=0.
  - IDLE → SER when core_pt_vld & core_pt_rdy. The adapter captures core_pt into the result register and sets beat index 0.
  - SER: m_vld=1, m_data = res[127 - idx*OUT_W -: OUT_W], m_last = (idx==NO-1).
  - On m_vld & m_rdy & !m_last: idx+1.
  - On m_vld & m_rdy & m_last: blk_out_cnt+1. The FSM returns to IDLE, or stays in SER with idx=0 and a new capture if core_pt_vld is high that cycle.
- **core_pt_rdy** = !rst & (state==IDLE | (m_vld & m_rdy & m_last)). This gives zero-bubble back-to-back blocks.
- m_data, m_vld and m_last are driven from registers only; there is no input-to-output combinational path.
- **Counters** wrap from 2^CNT_W-1 to 0.

## Timing
- **Reset values:**
  - Outputs: core_ct=0, core_ct_vld=0, m_data=0, m_vld=0, m_last=0, blk_in_cnt=0, blk_out_cnt=0.
  - State: FSM=IDLE, both indices 0.
  - Combinational outputs: s_rdy=0 and core_pt_rdy=0 while rst is high; both are 1 in the first cycle after rst deasserts.
- **Reset mid-operation:** a partial gather, a pending core_ct and an in-progress serialisation are all discarded. No beat is emitted after reset.
- **Input latency:** last word accepted at cycle t → core_ct_vld=1 at t+1.
- **Output latency:** core_pt handshake at cycle t → first beat on m_data with m_vld=1 at t+1.
- **Sustained rate:** one block per NI cycles in, one block per NO cycles out, with no idle cycles when the neighbours are always ready.
- **Signal stability:**
  - m_data and m_last are stable while m_vld=1 and m_rdy=0.
  - core_ct is stable while core_ct_vld=1 and core_ct_rdy=0.

## Test plan
1. **Basic path, IN_W=8, OUT_W=64.**
   - Stimulus: bytes 0x00..0x0F on consecutive cycles; core returns 128'h00112233445566778899AABBCCDDEEFF.
   - Required: core_ct=128'h000102030405060708090A0B0C0D0E0F with core_ct_vld one cycle after byte 0x0F.
   - Required: m_data=64'h0011223344556677 with m_last=0, then 64'h8899AABBCCDDEEFF with m_last=1; blk_in_cnt=1 and blk_out_cnt=1.
2. **Core-side backpressure.**
   - Stimulus: hold core_ct_rdy=0 for 5 cycles after the block completes, with s_vld=1 throughout.
   - Required: s_rdy=0 and core_ct constant for those 5 cycles.
   - Required: in the cycle core_ct_rdy=1, byte 0x10 is accepted and the next block is gathered from 0x10.
3. **Output backpressure and zero-bubble hand-off.**
   - Stimulus: m_rdy toggling 1,0,1,0; core_pt_vld high during the last-beat handshake.
   - Required: each beat is held while m_rdy=0; core_pt_rdy=1 in the last-beat handshake cycle; the new block's first beat appears the next cycle.
4. **Flush.**
   - Stimulus: flush for one cycle after 7 bytes, with s_vld=1 in the flush cycle, then bytes 0xA0..0xAF.
   - Required: the byte in the flush cycle is not accepted; core_ct=128'hA0A1...AF; blk_in_cnt increments by exactly 1.
5. **Reset mid-serialisation.**
   - Stimulus: assert rst after the first m_* beat.
   - Required: m_vld=0 and m_last=0 in the following cycle; both counters read 0; no second beat is emitted.
6. **Parameter sweep, IN_W=32, OUT_W=32, CNT_W=4.**
   - Stimulus: 17 blocks, 4 words in per block.
   - Required: 4 beats out per block with m_last on beat 3; blk_in_cnt and blk_out_cnt wrap from 0xF to 0x0 and read 1 at the end.

Source files
------------

// File: rtl/aes_stream_adapter.sv
// Stream adapter for the AES decrypt core: gathers IN_W-bit ciphertext words into
// 128-bit blocks for the core and serialises each 128-bit plaintext into OUT_W-bit beats.
//
// state | meaning
// IDLE  | no result held; ready to capture core_pt
// SER   | emitting beats of the captured result, MSB beat first
module aes_stream_adapter #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_vld,
  output logic             s_rdy,
  output logic [127:0]     core_ct,
  output logic             core_ct_vld,
  input  logic             core_ct_rdy,
  input  logic [127:0]     core_pt,
  input  logic             core_pt_vld,
  output logic             core_pt_rdy,
  output logic [OUT_W-1:0] m_data,
  output logic             m_vld,
  input  logic             m_rdy,
  output logic             m_last,
  output logic [CNT_W-1:0] blk_in_cnt,
  output logic [CNT_W-1:0] blk_out_cnt
);

  localparam int NI = 128 / IN_W;
  localparam int NO = 128 / OUT_W;
  localparam int IW = (NI > 1) ? $clog2(NI) : 1;
  localparam int OW = (NO > 1) ? $clog2(NO) : 1;

  // ---------------- input gather ----------------
  logic [IW-1:0] in_idx;
  logic [127:0]  gat_q;
  logic [127:0]  gat_shift;
  logic          s_acc;
  logic          ct_hs;
  logic          blk_done;

  generate
    if (IN_W == 128) begin : g_full_word
      assign gat_shift = s_data;
    end else begin : g_part_word
      assign gat_shift = {gat_q[127-IN_W:0], s_data};
    end
  endgenerate

  // core_ct_rdy feeds s_rdy combinationally so a block hand-off and the next
  // block's first word can share a cycle.
  assign s_rdy    = !rst && !flush && (!core_ct_vld || core_ct_rdy);
  assign s_acc    = s_vld && s_rdy;
  assign ct_hs    = core_ct_vld && core_ct_rdy;
  assign blk_done = s_acc && (in_idx == IW'(NI - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx      <= '0;
      gat_q       <= '0;
      core_ct     <= '0;
      core_ct_vld <= 1'b0;
      blk_in_cnt  <= '0;
    end else begin
      if (ct_hs) begin
        blk_in_cnt  <= blk_in_cnt + CNT_W'(1);
        core_ct_vld <= 1'b0;
      end
      if (s_acc) begin
        if (blk_done) begin
          core_ct     <= gat_shift;
          core_ct_vld <= 1'b1;
          in_idx      <= '0;
          gat_q       <= '0;
        end else begin
          gat_q  <= gat_shift;
          in_idx <= in_idx + IW'(1);
        end
      end else if (flush && !core_ct_vld) begin
        gat_q  <= '0;
        in_idx <= '0;
      end
    end
  end

  // ---------------- output serialiser ----------------
  typedef enum logic {ST_IDLE, ST_SER} state_t;

  state_t        state_q, state_d;
  logic [127:0]  res_q, res_d;
  logic [OW-1:0] idx_q, idx_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic          out_inc;
  logic          beat_hs;
  logic          end_hs;
  logic          pt_hs;

  assign beat_hs     = vld_q && m_rdy;
  assign end_hs      = beat_hs && last_q;
  assign core_pt_rdy = !rst && ((state_q == ST_IDLE) || end_hs);
  assign pt_hs       = core_pt_vld && core_pt_rdy;

  // res_q shifts left per beat, so the current beat always sits in the top bits.
  assign m_data = res_q[127 -: OUT_W];
  assign m_vld  = vld_q;
  assign m_last = last_q;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    out_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pt_hs) begin
          state_d = ST_SER;
          res_d   = core_pt;
          idx_d   = '0;
          vld_d   = 1'b1;
        end
      end
      ST_SER: begin
        if (beat_hs) begin
          if (last_q) begin
            out_inc = 1'b1;
            idx_d   = '0;
            if (pt_hs) begin
              res_d = core_pt;
            end else begin
              state_d = ST_IDLE;
              vld_d   = 1'b0;
            end
          end else begin
            res_d = res_q << OUT_W;
            idx_d = idx_q + OW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase
    last_d = vld_d && (idx_d == OW'(NO - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      res_q       <= '0;
      idx_q       <= '0;
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
      blk_out_cnt <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      if (out_inc) blk_out_cnt <= blk_out_cnt + CNT_W'(1);
    end
  end

endmodule
